// File: rtl/boot_sequencer_pkg.sv
// Shared types and defaults for the boot sequencer slice.
//   boot_state_t : run-controller FSM encoding
//   DEF_*        : default widths / timings used by the interface and top
//   max_u        : larger of two unsigned values (clear span sizing)
package boot_pkg;

  typedef enum logic [2:0] {
    CLR,
    RUN,
    DRAIN,
    FINISH,
    TIMEOUT
  } boot_state_t;

  localparam int unsigned DEF_DATA_W         = 8;
  localparam int unsigned DEF_DONE_HOLD      = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 500;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/boot_sequencer_if.sv
// Core / memory-clear bus between the boot sequencer and the processor core.
//   core_reset : 1 = core held in reset
//   core_done  : done flag from the core
//   rf_*       : register-file write port (we, waddr, wdata)
//   dm_*       : data-memory write port (we, addr, wdata)
// master = sequencer side, slave = core / memory side.
interface boot_sequencer_if
  import boot_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned RF_DEPTH = 16,
  parameter int unsigned DM_DEPTH = 256
);

  logic                        core_reset;
  logic                        core_done;
  logic                        rf_we;
  logic [$clog2(RF_DEPTH)-1:0] rf_waddr;
  logic [DATA_W-1:0]           rf_wdata;
  logic                        dm_we;
  logic [$clog2(DM_DEPTH)-1:0] dm_addr;
  logic [DATA_W-1:0]           dm_wdata;

  modport master (
    output core_reset, rf_we, rf_waddr, rf_wdata, dm_we, dm_addr, dm_wdata,
    input  core_done
  );

  modport slave (
    input  core_reset, rf_we, rf_waddr, rf_wdata, dm_we, dm_addr, dm_wdata,
    output core_done
  );

endinterface

// File: rtl/boot_sequencer_clear_walker.sv
// Clear-address walker: steps 0..N-1 (N = larger memory depth) while en is
// high, then raises a sticky finished flag until reset.
//   clk, reset      : system clock, synchronous active-high reset
//   en              : advance one address per edge
//   rf_addr/dm_addr : current address truncated to each memory's width
//   rf_en/dm_en     : current address lies inside that memory
//   finished        : address N-1 has already been issued
module clear_walker
  import boot_pkg::*;
#(
  parameter int unsigned RF_DEPTH = 16,
  parameter int unsigned DM_DEPTH = 256
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  output logic [$clog2(RF_DEPTH)-1:0] rf_addr,
  output logic [$clog2(DM_DEPTH)-1:0] dm_addr,
  output logic                        rf_en,
  output logic                        dm_en,
  output logic                        finished
);

  localparam int unsigned N  = max_u(RF_DEPTH, DM_DEPTH);
  localparam int unsigned AW = $clog2(N);

  logic [AW-1:0] cnt;
  logic          last;

  assign last = (cnt == AW'(N - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      finished <= 1'b0;
    end else if (en && !finished) begin
      if (last) finished <= 1'b1;
      else      cnt      <= cnt + AW'(1);
    end
  end

  assign rf_en   = (32'(cnt) < RF_DEPTH);
  assign dm_en   = (32'(cnt) < DM_DEPTH);
  assign rf_addr = cnt[$clog2(RF_DEPTH)-1:0];
  assign dm_addr = cnt[$clog2(DM_DEPTH)-1:0];

endmodule

// File: rtl/boot_sequencer.sv
// Hardware run controller: zeroes register file and data memory, releases
// core reset, counts run cycles, qualifies core_done (minimum-run window plus
// drain delay) and flags a timeout if the core never finishes.
//   clk, reset  : system clock, synchronous active-high reset
//   bus         : core control and memory clear ports (master side)
//   done        : run completed normally (sticky until reset)
//   timeout     : run aborted by the cycle limit (sticky until reset)
//   cycle_count : run cycles elapsed (frozen on qualified done)
module boot_sequencer
  import boot_pkg::*;
#(
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned RF_DEPTH       = 16,
  parameter int unsigned DM_DEPTH       = 256,
  parameter int unsigned MIN_RUN        = 5,
  parameter int unsigned DONE_HOLD      = DEF_DONE_HOLD,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  boot_sequencer_if.master     bus,
  output logic                 done,
  output logic                 timeout,
  output logic [CNT_W-1:0]     cycle_count
);

  localparam int unsigned DW = $clog2(DONE_HOLD + 1);

  boot_state_t                 state;
  logic [DW-1:0]               dcnt;
  logic [DATA_W-1:0]           zero_word;
  logic [$clog2(RF_DEPTH)-1:0] w_rf_addr;
  logic [$clog2(DM_DEPTH)-1:0] w_dm_addr;
  logic                        w_rf_en;
  logic                        w_dm_en;
  logic                        w_finished;

  assign zero_word    = '0;
  assign bus.rf_wdata = zero_word;
  assign bus.dm_wdata = zero_word;

  clear_walker #(
    .RF_DEPTH (RF_DEPTH),
    .DM_DEPTH (DM_DEPTH)
  ) u_walker (
    .clk      (clk),
    .reset    (reset),
    .en       (state == CLR),
    .rf_addr  (w_rf_addr),
    .dm_addr  (w_dm_addr),
    .rf_en    (w_rf_en),
    .dm_en    (w_dm_en),
    .finished (w_finished)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= CLR;
      dcnt           <= '0;
      bus.core_reset <= 1'b1;
      bus.rf_we      <= 1'b0;
      bus.dm_we      <= 1'b0;
      bus.rf_waddr   <= '0;
      bus.dm_addr    <= '0;
      done           <= 1'b0;
      timeout        <= 1'b0;
      cycle_count    <= '0;
    end else begin
      case (state)
        CLR: begin
          // The walker runs one edge ahead of the registered write port, so
          // 'finished' is seen on the edge after the final write is issued.
          if (w_finished) begin
            state          <= RUN;
            bus.core_reset <= 1'b0;
            bus.rf_we      <= 1'b0;
            bus.dm_we      <= 1'b0;
          end else begin
            bus.rf_we    <= w_rf_en;
            bus.dm_we    <= w_dm_en;
            bus.rf_waddr <= w_rf_addr;
            bus.dm_addr  <= w_dm_addr;
          end
        end
        RUN: begin
          // Qualified done takes priority over the timeout limit.
          if (cycle_count >= CNT_W'(MIN_RUN) && bus.core_done) begin
            state <= DRAIN;
            dcnt  <= '0;
          end else if (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state          <= TIMEOUT;
            timeout        <= 1'b1;
            bus.core_reset <= 1'b1;
            cycle_count    <= CNT_W'(TIMEOUT_CYCLES);
          end else begin
            cycle_count <= cycle_count + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (dcnt == DW'(DONE_HOLD - 1)) begin
            state          <= FINISH;
            done           <= 1'b1;
            bus.core_reset <= 1'b1;
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        FINISH, TIMEOUT: ;
        default: state <= CLR;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_sequencer.sv
module tb_boot_sequencer;
  import boot_pkg::*;

  localparam int unsigned RF_D    = 16;
  localparam int unsigned DM_D    = 256;
  localparam int unsigned MINR    = 5;
  localparam int unsigned HOLD    = 4;
  localparam int unsigned TLIM    = 500;
  localparam int unsigned NCLR    = 256;

  typedef struct packed {
    logic        rf;
    logic [31:0] addr;
  } wr_t;

  typedef struct packed {
    logic        is_done;
    logic [31:0] count;
    logic [31:0] edge_no;
  } out_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        done;
  logic        timeout;
  logic [15:0] cycle_count;

  int checks = 0;
  int failures = 0;

  wr_t  wq[$];
  out_t oq[$];

  boot_sequencer_if #(.DATA_W(8), .RF_DEPTH(RF_D), .DM_DEPTH(DM_D)) bus ();

  boot_sequencer #(
    .DATA_W         (8),
    .RF_DEPTH       (RF_D),
    .DM_DEPTH       (DM_D),
    .MIN_RUN        (MINR),
    .DONE_HOLD      (HOLD),
    .TIMEOUT_CYCLES (TLIM),
    .CNT_W          (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .done        (done),
    .timeout     (timeout),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Clear-write monitor: every observed write must match the next expected one.
  always @(negedge clk) begin
    if (bus.dm_we || bus.rf_we) begin
      if (wq.size() == 0) begin
        chk("unexpected_write", 32'(bus.dm_addr), 32'hFFFF_FFFF);
      end else begin
        wr_t w;
        w = wq.pop_front();
        chk("wr_dm_we",    32'(bus.dm_we),    32'(w.addr < DM_D));
        chk("wr_rf_we",    32'(bus.rf_we),    32'(w.rf));
        chk("wr_dm_addr",  32'(bus.dm_addr),  w.addr % DM_D);
        if (w.rf) chk("wr_rf_addr", 32'(bus.rf_waddr), w.addr % RF_D);
        chk("wr_dm_wdata", 32'(bus.dm_wdata), 32'd0);
        chk("wr_rf_wdata", 32'(bus.rf_wdata), 32'd0);
      end
    end
  end

  // Drives core_done high for run cycles lo..hi; abort_addr>=0 asserts reset
  // mid-clear once that address is written.
  task automatic run_case(input int lo, input int hi, input int abort_addr);
    int   e;
    int   j;
    int   s;
    bit   fell;
    bit   got;
    out_t o;

    @(negedge clk); #1;
    reset = 1'b1;
    bus.core_done = 1'b0;
    wq.delete();
    oq.delete();
    @(negedge clk); #1;
    chk("rst_core_reset",  32'(bus.core_reset), 32'd1);
    chk("rst_dm_we",       32'(bus.dm_we),      32'd0);
    chk("rst_rf_we",       32'(bus.rf_we),      32'd0);
    chk("rst_dm_addr",     32'(bus.dm_addr),    32'd0);
    chk("rst_done",        32'(done),           32'd0);
    chk("rst_timeout",     32'(timeout),        32'd0);
    chk("rst_cycle_count", 32'(cycle_count),    32'd0);
    @(negedge clk); #1;

    for (int a = 0; a < int'(NCLR); a++) begin
      wr_t w;
      w.rf   = (a < int'(RF_D));
      w.addr = 32'(a);
      wq.push_back(w);
    end
    reset = 1'b0;

    e = 0;
    fell = 1'b0;
    while (e < 400 && !fell) begin
      @(negedge clk); #1;
      e++;
      if (abort_addr >= 0 && bus.dm_we && int'(bus.dm_addr) == abort_addr) begin
        reset = 1'b1;
        wq.delete();
        @(negedge clk); #1;
        chk("abort_dm_we",      32'(bus.dm_we),      32'd0);
        chk("abort_core_reset", 32'(bus.core_reset), 32'd1);
        return;
      end
      if (!bus.core_reset) fell = 1'b1;
    end
    chk("core_reset_fall_edge", 32'(e), 32'(NCLR + 1));
    chk("clear_writes_left",    32'(wq.size()), 32'd0);
    chk("run_start_count",      32'(cycle_count), 32'd0);

    s = (lo > int'(MINR)) ? lo : int'(MINR);
    if (s <= hi && s <= int'(TLIM) - 1) begin
      o.is_done = 1'b1;
      o.count   = 32'(s);
      o.edge_no = 32'(s + 1 + int'(HOLD));
    end else begin
      o.is_done = 1'b0;
      o.count   = 32'(TLIM);
      o.edge_no = 32'(TLIM);
    end
    oq.push_back(o);

    j = 0;
    got = 1'b0;
    bus.core_done = (lo <= 0 && 0 <= hi);
    while (j < 700 && !got) begin
      @(negedge clk); #1;
      j++;
      bus.core_done = (j >= lo && j <= hi);
      if (o.is_done && 32'(j) == o.edge_no - 1) begin
        chk("drain_done_low",     32'(done),           32'd0);
        chk("drain_core_running", 32'(bus.core_reset), 32'd0);
      end
      if (done || timeout) begin
        out_t x;
        got = 1'b1;
        x = oq.pop_front();
        chk("out_done",       32'(done),           32'(x.is_done));
        chk("out_timeout",    32'(timeout),        32'(!x.is_done));
        chk("out_core_reset", 32'(bus.core_reset), 32'd1);
        chk("out_count",      32'(cycle_count),    x.count);
        chk("out_edge",       32'(j),              x.edge_no);
      end
    end
    if (!got) chk("outcome_seen", 32'd0, 32'd1);

    bus.core_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("sticky_done",    32'(done),        32'(o.is_done));
      chk("sticky_timeout", 32'(timeout),     32'(!o.is_done));
      chk("sticky_count",   32'(cycle_count), o.count);
    end
  endtask

  initial begin
    bus.core_done = 1'b0;
    run_case(20, 20, -1);     // normal finish, freeze at 20
    run_case(20, 20, -1);     // reset from FINISH, identical repeat
    run_case(2, 3, -1);       // early done ignored -> timeout
    run_case(499, 800, -1);   // done on the last run cycle wins
    run_case(0, 800, -1);     // done held from start qualifies at MIN_RUN
    run_case(4, 4, -1);       // done only one cycle before MIN_RUN -> timeout
    run_case(0, -1, 100);     // reset mid-clear
    run_case(20, 20, -1);     // full clear after mid-clear abort
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=%0d exp=%0d", 0, 1);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
